// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between N requesters, one transaction per 3 cycles.
// Define ARB_LOCK_EN to honour the per-requester lock input (bounded by LOCK_MAX).
module ram_arbiter #(
  parameter int N        = 4,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N-1:0]    lock,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   rdata,
  output logic [2:0]      gnt_id,
  output logic            busy,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      gnt_id_q, gnt_id_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            locked_q, locked_d;
  logic [7:0]      lock_cnt_q, lock_cnt_d;

  logic            found;
  logic [2:0]      win;
  logic [2:0]      idx;
  logic            take;
  logic [2:0]      sel;

  function automatic logic [N-1:0] onehot(input logic [2:0] i);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  // base and off are both below N, so one conditional subtract is a full modulo
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return 3'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = wrap_idx(rr_ptr_q, i);
      if (!found && |(req & onehot(idx))) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    locked_d    = locked_q;
    lock_cnt_d  = lock_cnt_q;
    take        = found;
    sel         = win;

    case (state_q)
      IDLE: begin
`ifdef ARB_LOCK_EN
        if (locked_q) begin
          if (|(req & onehot(gnt_id_q))) begin
            take = 1'b1;
            sel  = gnt_id_q;
          end else begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
          end
        end
`endif
        if (take) begin
          gnt_id_d    = sel;
          ram_we_d    = |(we & onehot(sel));
          ram_addr_d  = m_addr[int'(sel)*AW +: AW];
          ram_wdata_d = m_wdata[int'(sel)*DW +: DW];
          state_d     = ACCESS;
        end
      end

      ACCESS: state_d = RESP;

      RESP: begin
        state_d = IDLE;
        if (!ram_we_q) rdata_d = ram_rdata;
`ifdef ARB_LOCK_EN
        if (|(lock & onehot(gnt_id_q)) && (int'(lock_cnt_q) < LOCK_MAX - 1)) begin
          locked_d   = 1'b1;
          lock_cnt_d = lock_cnt_q + 8'd1;
        end else begin
          locked_d   = 1'b0;
          lock_cnt_d = '0;
          rr_ptr_d   = wrap_idx(gnt_id_q, 1);
        end
`else
        rr_ptr_d = wrap_idx(gnt_id_q, 1);
`endif
      end

      default: state_d = IDLE;
    endcase

`ifndef ARB_LOCK_EN
    locked_d   = 1'b0;
    lock_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      locked_q    <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      locked_q    <= locked_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

`ifndef ARB_LOCK_EN
  logic lock_unused;
  assign lock_unused = ^{lock, locked_q, lock_cnt_q} ^ (LOCK_MAX > 0);
`endif

  // Read data arrives from the RAM during RESP, so pass it straight through while acking
  assign rdata     = (state_q == RESP && !ram_we_q) ? ram_rdata : rdata_q;
  assign ack       = (state_q == RESP) ? onehot(gnt_id_q) : '0;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q != IDLE);
  assign ram_en    = (state_q == ACCESS);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small synchronous RAM model.
// Lock expectations follow whether ARB_LOCK_EN is defined for the build.
module tb_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] mAddr;
  logic [N*DW-1:0] mWdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [2:0]      gntId;
  logic            busy;
  logic            ramEn;
  logic            ramWe;
  logic [AW-1:0]   ramAddr;
  logic [DW-1:0]   ramWdata;
  logic [DW-1:0]   ramRdata;

  logic [DW-1:0]   mem [0:65535];
  int              cycle;
  int              checkCount;
  int              errorCount;

  ram_arbiter #(.N(N), .AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .m_addr(mAddr), .m_wdata(mWdata), .ack(ack), .rdata(rdata),
    .gnt_id(gntId), .busy(busy), .ram_en(ramEn), .ram_we(ramWe),
    .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_rdata(ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // RAM model: write or registered read on an ram_en cycle
  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      else       ramRdata <= mem[ramAddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w, input int who,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = r;
    we  = w;
    mAddr[who*AW +: AW]  = a;
    mWdata[who*DW +: DW] = d;
  endtask

  task automatic waitAck(input string tag, output logic [N-1:0] seen, output int at);
    seen = '0;
    at   = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen = ack;
        at   = cycle;
        break;
      end
    end
    if (at < 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    req = '0; we = '0; lock = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [N-1:0] seen;
  int           at;
  int           lastAt;
  int           expOrder [10];

  initial begin
    checkCount = 0;
    errorCount = 0;
    cycle      = 0;
    ramRdata   = '0;
    reset      = 1'b0;
    req = '0; we = '0; lock = '0; mAddr = '0; mWdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0040] = 16'hBEEF;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ram_en", 32'(ramEn), 32'h0);
    checkOutput("rst_rdata", 32'(rdata), 32'h0);
    checkOutput("rst_gnt", 32'(gntId), 32'h0);
    reset = 1'b1;

    // Single read by requester 1
    @(negedge clk);
    applyStimulus(4'b0010, 4'b0000, 1, 16'h0040, 16'h0);
    @(negedge clk);
    checkOutput("rd_ram_en", 32'(ramEn), 32'h1);
    checkOutput("rd_ram_addr", 32'(ramAddr), 32'h0040);
    checkOutput("rd_gnt", 32'(gntId), 32'h1);
    checkOutput("rd_busy", 32'(busy), 32'h1);
    checkOutput("rd_ack_early", 32'(ack), 32'h0);
    @(negedge clk);
    checkOutput("rd_ack", 32'(ack), 32'h2);
    checkOutput("rd_rdata", 32'(rdata), 32'hBEEF);
    checkOutput("rd_ram_en_off", 32'(ramEn), 32'h0);
    req = '0;
    @(negedge clk);
    checkOutput("rd_ack_drop", 32'(ack), 32'h0);
    checkOutput("rd_idle", 32'(busy), 32'h0);

    // Write then read by requester 0
    applyStimulus(4'b0001, 4'b0001, 0, 16'h0010, 16'h1234);
    @(negedge clk);
    checkOutput("wr_ram_en", 32'(ramEn), 32'h1);
    checkOutput("wr_ram_we", 32'(ramWe), 32'h1);
    checkOutput("wr_ram_addr", 32'(ramAddr), 32'h0010);
    checkOutput("wr_ram_wdata", 32'(ramWdata), 32'h1234);
    @(negedge clk);
    checkOutput("wr_ack", 32'(ack), 32'h1);
    we = 4'b0000;
    @(negedge clk);
    checkOutput("wr_rd_idle", 32'(busy), 32'h0);
    @(negedge clk);
    checkOutput("wr_rd_ram_we", 32'(ramWe), 32'h0);
    @(negedge clk);
    checkOutput("wr_rd_ack", 32'(ack), 32'h1);
    checkOutput("wr_rd_rdata", 32'(rdata), 32'h1234);
    req = '0;
    @(negedge clk);
    checkOutput("wr_rd_hold", 32'(rdata), 32'h1234);

    // Contention from rr_ptr=0: order 0,1,2,3 then 0 again, 3 cycles apart
    applyReset();
    @(negedge clk);
    req = 4'b1111; we = '0;
    lastAt = -1;
    for (int k = 0; k < 5; k++) begin
      waitAck("rr", seen, at);
      checkOutput($sformatf("rr_ack%0d", k), 32'(seen), 32'(4'b0001 << (k % 4)));
      if (lastAt >= 0) checkOutput($sformatf("rr_gap%0d", k), 32'(at - lastAt), 32'd3);
      lastAt = at;
      req = req & ~seen;
      if (k == 3) req = 4'b0001;
    end
    req = '0;

    // Async reset in the middle of an ACCESS cycle
    @(negedge clk);
    @(negedge clk);
    applyStimulus(4'b0100, 4'b0100, 2, 16'h0020, 16'h5555);
    @(negedge clk);
    checkOutput("abort_pre_en", 32'(ramEn), 32'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_ram_en", 32'(ramEn), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_gnt", 32'(gntId), 32'h0);
    req = '0; we = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort_noack", 32'(ack), 32'h0);
    end
    reset = 1'b1;
    checkOutput("abort_nowrite", 32'(mem[16'h0020]), 32'h0);
    @(negedge clk);
    applyStimulus(4'b1000, 4'b0000, 3, 16'h0040, 16'h0);
    @(negedge clk);
    checkOutput("post_gnt", 32'(gntId), 32'h3);
    checkOutput("post_ram_en", 32'(ramEn), 32'h1);
    @(negedge clk);
    checkOutput("post_ack", 32'(ack), 32'h8);
    checkOutput("post_rdata", 32'(rdata), 32'hBEEF);
    req = '0;

    // Lock: requester 2 locked, requester 0 waiting
`ifdef ARB_LOCK_EN
    expOrder = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2};
`else
    expOrder = '{2, 0, 2, 0, 2, 0, 2, 0, 2, 0};
`endif
    applyReset();
    @(negedge clk);
    req = 4'b0100; lock = 4'b0100; we = '0;
    @(negedge clk);
    req = 4'b0101;
    lastAt = -1;
    for (int k = 0; k < 10; k++) begin
      waitAck("lk", seen, at);
      checkOutput($sformatf("lk_ack%0d", k), 32'(seen), 32'(4'b0001 << expOrder[k]));
      if (lastAt >= 0) checkOutput($sformatf("lk_gap%0d", k), 32'(at - lastAt), 32'd3);
      lastAt = at;
    end
    req = '0; lock = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
